// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal group between a bus master/decoder and
// the SRAM slave. HREADY is the bus-wide ready, driven from the master side.
`timescale 1ns/1ps
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a byte-addressable internal memory.
// Byte/half/word transfers, two-cycle ERROR for illegal size or misalignment.
// Optional fixed wait states: define AHB_SLV_WAIT_EN to insert WAIT_CYCLES
// stall cycles on every legal accepted transfer; otherwise all are zero-wait.
`timescale 1ns/1ps
module ahb_sram_slave #(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            HCLK,
  input  logic            HRST,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
  localparam int unsigned WORDS  = MEM_BYTES / 4;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

`ifdef AHB_SLV_WAIT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_accept_state;

  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic                r_write;
  logic [31:0]         r_mem [WORDS];

  logic                w_can_accept;
  logic                w_accept;
  logic                w_illegal;
  logic [3:0]          w_lane_en;
  logic [ADDR_W-3:0]   w_word;
  logic                w_unused;

`ifdef AHB_SLV_WAIT_EN
  logic [3:0]          r_wait_cnt;
  logic [3:0]          w_wait_cnt_nxt;
`endif

  // Address phase is only sampled in states that present HREADYOUT=1.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                        (r_state == ST_ERR2);
  assign w_accept     = w_can_accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign w_word       = r_addr[ADDR_W-1:2];

`ifdef AHB_SLV_WAIT_EN
  assign w_unused = ^{bus.HADDR[31:ADDR_W], bus.HBURST, bus.HPROT};
`else
  assign w_unused = ^{bus.HADDR[31:ADDR_W], bus.HBURST, bus.HPROT, WAIT_CYCLES[0]};
`endif

  // Classify the incoming address phase: bad size or misaligned half/word.
  always_comb begin
    w_illegal = 1'b0;
    case (bus.HSIZE)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = bus.HADDR[0];
      3'b010:  w_illegal = |bus.HADDR[1:0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Where an accepted address phase leads; errors win over wait states.
  always_comb begin
    w_accept_state = ST_IDLE;
    if (w_accept) begin
      if (w_illegal) begin
        w_accept_state = ST_ERR1;
      end
`ifdef AHB_SLV_WAIT_EN
      else if (WAIT_CYCLES != 0) begin
        w_accept_state = ST_WAIT;
      end
`endif
      else begin
        w_accept_state = ST_DATA;
      end
    end
  end

  // State register (and wait counter when wait states are built in).
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      r_state    <= ST_IDLE;
`ifdef AHB_SLV_WAIT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
`ifdef AHB_SLV_WAIT_EN
      r_wait_cnt <= w_wait_cnt_nxt;
`endif
    end
  end

  // Next state and bus response outputs.
  always_comb begin
    w_state_nxt    = r_state;
`ifdef AHB_SLV_WAIT_EN
    w_wait_cnt_nxt = r_wait_cnt;
`endif
    bus.HREADYOUT  = 1'b1;
    bus.HRESP      = RESP_OKAY;
    bus.HRDATA     = '0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = w_accept_state;
      end
`ifdef AHB_SLV_WAIT_EN
      ST_WAIT: begin
        bus.HREADYOUT  = 1'b0;
        w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        if (r_wait_cnt <= 4'd1) begin
          w_state_nxt = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (!r_write) begin
          bus.HRDATA = r_mem[w_word];
        end
        w_state_nxt = w_accept_state;
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = RESP_ERROR;
        w_state_nxt   = ST_ERR2;
      end
      ST_ERR2: begin
        bus.HRESP   = RESP_ERROR;
        w_state_nxt = w_accept_state;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
`ifdef AHB_SLV_WAIT_EN
    if (w_accept_state == ST_WAIT) begin
      w_wait_cnt_nxt = 4'(WAIT_CYCLES);
    end
`endif
  end

  // Capture the address-phase controls of each accepted transfer.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= bus.HADDR[ADDR_W-1:0];
      r_size  <= bus.HSIZE;
      r_write <= bus.HWRITE;
    end
  end

  // Little-endian byte lanes touched by the registered transfer.
  always_comb begin
    w_lane_en = 4'b0000;
    case (r_size)
      3'b000:  w_lane_en = 4'b0001 << r_addr[1:0];
      3'b001:  w_lane_en = r_addr[1] ? 4'b1100 : 4'b0011;
      3'b010:  w_lane_en = 4'b1111;
      default: w_lane_en = 4'b0000;
    endcase
  end

  // Commit write data at the end of the DATA cycle; contents are not reset.
  always_ff @(posedge HCLK) begin
    if (r_state == ST_DATA && r_write) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (w_lane_en[n]) begin
          r_mem[w_word][8*n +: 8] <= bus.HWDATA[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed AHB-Lite transfers against ahb_sram_slave with
// hand-computed expected read data, stall counts and responses.
// Expected stall count follows AHB_SLV_WAIT_EN (WAIT_CYCLES=2 when defined).
`timescale 1ns/1ps
module tb_ahb_sram_slave;

  localparam int unsigned WAITS = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int unsigned EXP_WAIT = WAITS;
`else
  localparam int unsigned EXP_WAIT = 0;
`endif

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRST = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] burst_data [4] = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_0001};
  logic        idle_sel   [3] = '{1'b1, 1'b1, 1'b0};
  logic [1:0]  idle_trans [3] = '{T_IDLE, T_BUSY, T_NSEQ};

  ahb_sram_slave_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_slave #(
    .MEM_BYTES   (4096),
    .WAIT_CYCLES (WAITS)
  ) u_dut (
    .HCLK (HCLK),
    .HRST (HRST),
    .bus  (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic addr_phase(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                            input logic wr, input logic [2:0] size);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HBURST = 3'b000;
    bus.HPROT  = 4'b0011;
  endtask

  task automatic bus_idle();
    addr_phase(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000);
  endtask

  // Called just after the edge that starts a data phase; returns at the
  // falling edge of the cycle where HREADYOUT is high.
  task automatic wait_ready(input string tag, input int unsigned exp_stalls, input logic [1:0] exp_resp);
    int unsigned stalls = 0;
    @(negedge HCLK);
    while (bus.HREADYOUT !== 1'b1 && stalls < 32) begin
      check({tag, "_rsp_stall"}, 32'(bus.HRESP), 32'(exp_resp));
      stalls++;
      @(negedge HCLK);
    end
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_rsp"}, 32'(bus.HRESP), 32'(exp_resp));
  endtask

  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    addr_phase(1'b1, T_NSEQ, addr, wr, size);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = wdata;
    wait_ready(tag, exp_err ? 1 : EXP_WAIT, exp_err ? 2'b01 : 2'b00);
    check({tag, "_rdata"}, bus.HRDATA, exp_rd);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HWDATA = '0;
    bus_idle();
    #2 HRST = 1'b1;
    #10;
    check("por_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    check("por_hresp", 32'(bus.HRESP), 32'h0);
    check("por_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1 HRST = 1'b0;
    @(posedge HCLK); #1;

    // Reset in the middle of a write data phase must abort the write.
    xfer("wr40", 32'h40, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 1'b0);
    addr_phase(1'b1, T_NSEQ, 32'h40, 1'b1, 3'b010);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'hCAFE_F00D;
    #2 HRST = 1'b1;
    #1;
    check("rst_wr_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    check("rst_wr_hresp", 32'(bus.HRESP), 32'h0);
    check("rst_wr_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1 HRST = 1'b0;
    xfer("rd40_after_rst", 32'h40, 1'b0, 3'b010, 32'h0, 32'h0000_0000, 1'b0);

    // Reset during the first ERROR cycle returns outputs to idle at once.
    addr_phase(1'b1, T_NSEQ, 32'h44, 1'b0, 3'b011);
    @(posedge HCLK); #1;
    bus_idle();
    #1;
    check("err1_pre_hreadyout", 32'(bus.HREADYOUT), 32'h0);
    check("err1_pre_hresp", 32'(bus.HRESP), 32'h1);
    HRST = 1'b1;
    #1;
    check("err1_rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    check("err1_rst_hresp", 32'(bus.HRESP), 32'h0);
    @(posedge HCLK); #1 HRST = 1'b0;

    // Word write then pipelined read of the same word.
    addr_phase(1'b1, T_NSEQ, 32'h10, 1'b1, 3'b010);
    @(posedge HCLK); #1;
    bus.HWDATA = 32'h1234_5678;
    addr_phase(1'b1, T_NSEQ, 32'h10, 1'b0, 3'b010);
    wait_ready("b2b_wr", EXP_WAIT, 2'b00);
    check("b2b_wr_rdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    bus_idle();
    wait_ready("b2b_rd", EXP_WAIT, 2'b00);
    check("b2b_rd_rdata", bus.HRDATA, 32'h1234_5678);
    @(posedge HCLK); #1;

    // Byte and halfword lane enables; unused lanes of HWDATA carry junk.
    xfer("wr20", 32'h20, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 1'b0);
    xfer("wrb21", 32'h21, 1'b1, 3'b000, 32'h5555_AA55, 32'h0, 1'b0);
    xfer("wrh22", 32'h22, 1'b1, 3'b001, 32'hBEEF_1234, 32'h0, 1'b0);
    xfer("rd20", 32'h20, 1'b0, 3'b010, 32'h0, 32'hBEEF_AA00, 1'b0);

    // Illegal transfers: ERROR response and memory untouched.
    xfer("wr04", 32'h04, 1'b1, 3'b010, 32'hA5A5_A5A5, 32'h0, 1'b0);
    xfer("err_word06", 32'h06, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("err_size3", 32'h04, 1'b1, 3'b011, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("err_half05", 32'h05, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("err_rd06", 32'h06, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    xfer("rd04_after_err", 32'h04, 1'b0, 3'b010, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // IDLE and BUSY with HSEL=1, NONSEQ with HSEL=0: no action.
    bus.HWDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      addr_phase(idle_sel[i], idle_trans[i], 32'h04, 1'b1, 3'b010);
      for (int c = 0; c < 2; c++) begin
        @(negedge HCLK);
        check($sformatf("noact%0d_c%0d_hreadyout", i, c), 32'(bus.HREADYOUT), 32'h1);
        check($sformatf("noact%0d_c%0d_hresp", i, c), 32'(bus.HRESP), 32'h0);
        @(posedge HCLK); #1;
      end
    end
    bus_idle();
    @(posedge HCLK); #1;
    xfer("rd04_after_noact", 32'h04, 1'b0, 3'b010, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // INCR4 word read burst, one data phase per beat.
    for (int i = 0; i < 4; i++) begin
      xfer($sformatf("burst_pre%0d", i), 32'h50 + 32'(4 * i), 1'b1, 3'b010, burst_data[i], 32'h0, 1'b0);
    end
    addr_phase(1'b1, T_NSEQ, 32'h50, 1'b0, 3'b010);
    bus.HBURST = 3'b011;
    @(posedge HCLK); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        addr_phase(1'b1, T_SEQ, 32'h50 + 32'(4 * (i + 1)), 1'b0, 3'b010);
        bus.HBURST = 3'b011;
      end else begin
        bus_idle();
      end
      wait_ready($sformatf("burst%0d", i), EXP_WAIT, 2'b00);
      check($sformatf("burst%0d_rdata", i), bus.HRDATA, burst_data[i]);
      @(posedge HCLK); #1;
    end

    @(negedge HCLK);
    check("end_hrdata", bus.HRDATA, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave terminating the bus signal group (HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA → HRDATA/HRESP/HREADY) inside a simulation or FPGA test system. It sits directly downstream of the bus master and address decoder, and backs its region with an internal byte-addressable memory. It supports byte, halfword and word transfers, optional fixed wait states, and a two-cycle ERROR response for illegal transfers. It is the synthesizable counterpart the master driver and monitor exercise.

## Interface
- MEM_BYTES, 4096, memory size in bytes (power of two, ≥4); offset = HADDR[log2(MEM_BYTES)-1:0], upper bits ignored (region selection is done by HSEL).
- WAIT_CYCLES, 2, wait states inserted per accepted transfer when AHB_SLV_WAIT_EN is defined (0..15).

- HCLK  in  1  bus clock; all state updates on rising edge.
- HRST  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  transfer address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; others illegal.
- HBURST  in  3  accepted, ignored (each beat handled independently).
- HPROT  in  4  accepted, ignored.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-wide ready (previous transfer completing).
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 OKAY, 01 ERROR.
- HRDATA  out  32  read data.

## Operation
- Accept: at a rising edge with HSEL & HREADY & HTRANS[1] — register address, size, write flag; transfer enters data phase next cycle. IDLE/BUSY or HSEL=0 → no action, OKAY, zero wait.
- Illegal transfer: HSIZE>010, or misaligned (half with HADDR[0]=1, word with HADDR[1:0]≠00). Takes precedence over wait states; memory not modified.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. Accept legal → WAIT (wait count>0) or DATA; accept illegal → ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY; down-counter from WAIT_CYCLES; → DATA when count reaches 1.
  - DATA: HREADYOUT=1, HRESP=OKAY; write commits at end of this cycle; reads drive HRDATA. Next state as IDLE-accept rules (back-to-back pipelining), else IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2. ERR2: HREADYOUT=1, HRESP=ERROR; next state per IDLE-accept rules.
- Writes: little-endian lane enables from HSIZE/HADDR[1:0]; byte lane n ← HWDATA[8n+7:8n]; other bytes unchanged.
- Reads: HRDATA = full 32-bit word at registered word address (all lanes driven) while in DATA with HWRITE=0; HRDATA=0 in all other states.
- Read in data phase immediately following a write data phase to the same word returns the newly written data (memory read is combinational from the registered address).
- Memory contents not reset.

## Timing
- Reset (async assert, sync release): HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0. Reset mid-transfer aborts; pending write not committed.
- Zero-wait read/write: data phase is the single cycle after acceptance.
- With wait states: data phase = WAIT_CYCLES cycles of HREADYOUT=0, then one DATA cycle.
- ERROR: exactly two cycles, HREADYOUT 0 then 1, HRESP=01 in both.
- Address phase presented while HREADY=0 is not sampled; master holds it.

## Configuration
- AHB_SLV_WAIT_EN: defined → WAIT state used, WAIT_CYCLES inserted on every legal accepted transfer (WAIT_CYCLES=0 behaves as undefined). Undefined → WAIT state and counter removed, all legal transfers zero-wait; ERROR response unchanged.

## Test plan
- Reset: assert HRST mid write data phase → HREADYOUT=1, HRESP=00, HRDATA=0 immediately; read of target address shows no commit of 0xCAFEF00D.
- Word write 0x12345678 @0x10 then back-to-back read @0x10 → HRDATA=0x12345678 in read data phase, HRESP=00, no stall (macro undefined).
- Byte writes 0xAA @0x21, half write 0xBEEF @0x22 over prior word 0 at 0x20 → word read @0x20 = 0xBEEFAA00.
- Word access @0x06 and HSIZE=011 → two-cycle ERROR (HREADYOUT 0,1; HRESP 01,01); memory unchanged.
- AHB_SLV_WAIT_EN, WAIT_CYCLES=2: 4-beat INCR4 word read → each beat shows 2 cycles HREADYOUT=0 then 1; data correct per beat.
- IDLE/BUSY with HSEL=1, and NONSEQ with HSEL=0 → HREADYOUT=1, HRESP=00, no memory change.
